// File: rtl/self_attention_head_data_scatter_pkg.sv
// Shared helpers for the self-attention head split/merge stages.
// Counter widths come from clog2_min1 so single-value ranges still get one bit.
package self_attention_pkg;

  // Bit width able to index 0..x-1; never returns zero.
  function automatic int unsigned clog2_min1(input int unsigned x);
    return (x <= 32'd2) ? 32'd1 : $clog2(x);
  endfunction

endpackage

// File: rtl/self_attention_head_data_scatter_if.sv
// Bus bundle for the head scatter: joint input stream plus the shared-data,
// per-head valid/ready output side. master = upstream/downstream environment,
// slave = the scatter block. SELF_ATTN_SCATTER_LAST_EN adds data_out_last.
interface self_attention_head_data_scatter_if #(
  parameter int unsigned NumHeads  = 12,
  parameter int unsigned Precision = 16,
  parameter int unsigned Lanes     = 16
);

  logic [Precision-1:0] data_in [Lanes];
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic [Precision-1:0] data_out [Lanes];
  logic [NumHeads-1:0]  data_out_valid;
  logic [NumHeads-1:0]  data_out_ready;
`ifdef SELF_ATTN_SCATTER_LAST_EN
  logic                 data_out_last;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_last
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_last
  );
`else
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
`endif

endinterface

// File: rtl/self_attention_block_counter.sv
// Nested column/row block counter with a head/sub-block pair that tracks
// col / BLOCKS_PER_HEAD without a divider. Shared with the gather side.
// SELF_ATTN_SCATTER_LAST_EN adds last_o: final block of the tensor for a head.
module self_attention_block_counter
  import self_attention_pkg::*;
#(
  parameter int unsigned D0_BLOCKS       = 192,
  parameter int unsigned D1_BLOCKS       = 5,
  parameter int unsigned BLOCKS_PER_HEAD = 16,
  parameter int unsigned NUM_HEADS       = 12
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 advance_i,
  output logic [clog2_min1(NUM_HEADS)-1:0]     head_o
`ifdef SELF_ATTN_SCATTER_LAST_EN
  ,
  output logic                                 last_o
`endif
);

  localparam int unsigned ColW  = clog2_min1(D0_BLOCKS);
  localparam int unsigned RowW  = clog2_min1(D1_BLOCKS);
  localparam int unsigned SubW  = clog2_min1(BLOCKS_PER_HEAD);
  localparam int unsigned HeadW = clog2_min1(NUM_HEADS);

  localparam logic [ColW-1:0] ColMax = ColW'(D0_BLOCKS - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(D1_BLOCKS - 1);
  localparam logic [SubW-1:0] SubMax = SubW'(BLOCKS_PER_HEAD - 1);

  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [SubW-1:0]  sub_q, sub_d;
  logic [HeadW-1:0] head_q, head_d;
  logic             col_wrap;
  logic             sub_wrap;

  assign col_wrap = (col_q == ColMax);
  assign sub_wrap = (sub_q == SubMax);

  // Advance all counters together on each accepted block; col wrap resets heads.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    sub_d  = sub_q;
    head_d = head_q;
    if (advance_i) begin
      col_d = col_wrap ? '0 : col_q + ColW'(1);
      sub_d = (sub_wrap || col_wrap) ? '0 : sub_q + SubW'(1);
      if (col_wrap) begin
        head_d = '0;
        row_d  = (row_q == RowMax) ? '0 : row_q + RowW'(1);
      end else if (sub_wrap) begin
        head_d = head_q + HeadW'(1);
      end
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      sub_q  <= '0;
      head_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      sub_q  <= sub_d;
      head_q <= head_d;
    end
  end

  assign head_o = head_q;

`ifdef SELF_ATTN_SCATTER_LAST_EN
  assign last_o = (row_q == RowMax) && sub_wrap;
`endif

endmodule

// File: rtl/self_attention_head_data_scatter.sv
// Transmit side of the per-head split: routes each joint block to the head
// owning its column range through a single shared output register with a
// one-hot per-head valid. Build option SELF_ATTN_SCATTER_LAST_EN adds
// data_out_last marking each head's final block of the tensor.
module self_attention_head_data_scatter
  import self_attention_pkg::*;
#(
  parameter int unsigned NUM_HEADS                 = 12,
  parameter int unsigned IN_DATA_TENSOR_SIZE_DIM_0 = 768,
  parameter int unsigned IN_DATA_TENSOR_SIZE_DIM_1 = 20,
  parameter int unsigned IN_DATA_PARALLELISM_DIM_0 = 4,
  parameter int unsigned IN_DATA_PARALLELISM_DIM_1 = 4,
  parameter int unsigned IN_DATA_PRECISION_0       = 16
) (
  input logic                             clk,
  input logic                             rst,
  self_attention_head_data_scatter_if.slave bus_io
);

  localparam int unsigned D0_BLOCKS       = IN_DATA_TENSOR_SIZE_DIM_0 / IN_DATA_PARALLELISM_DIM_0;
  localparam int unsigned D1_BLOCKS       = IN_DATA_TENSOR_SIZE_DIM_1 / IN_DATA_PARALLELISM_DIM_1;
  localparam int unsigned BLOCKS_PER_HEAD = D0_BLOCKS / NUM_HEADS;
  localparam int unsigned Lanes           = IN_DATA_PARALLELISM_DIM_0 * IN_DATA_PARALLELISM_DIM_1;
  localparam int unsigned HeadW           = clog2_min1(NUM_HEADS);

  typedef logic [NUM_HEADS-1:0]           head_sel_t;
  typedef logic [IN_DATA_PRECISION_0-1:0] elem_t;

  elem_t            data_q [Lanes];
  elem_t            data_d [Lanes];
  head_sel_t        valid_q, valid_d;
  logic [HeadW-1:0] head_cnt;
  logic             in_fire;
  logic             out_fire;
  logic             in_ready;

  // A stalled selected head blocks everything; other heads' ready is masked off.
  assign out_fire = |(valid_q & bus_io.data_out_ready);
  assign in_ready = ~(|valid_q) | out_fire;
  assign in_fire  = bus_io.data_in_valid & in_ready;

`ifdef SELF_ATTN_SCATTER_LAST_EN
  logic last_q, last_d;
  logic cnt_last;
`endif

  self_attention_block_counter #(
    .D0_BLOCKS       (D0_BLOCKS),
    .D1_BLOCKS       (D1_BLOCKS),
    .BLOCKS_PER_HEAD (BLOCKS_PER_HEAD),
    .NUM_HEADS       (NUM_HEADS)
  ) u_block_counter (
    .clk       (clk),
    .rst       (rst),
    .advance_i (in_fire),
    .head_o    (head_cnt)
`ifdef SELF_ATTN_SCATTER_LAST_EN
    ,
    .last_o    (cnt_last)
`endif
  );

  // Load on input handshake (valid moves to the new head); else clear on drain.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
`ifdef SELF_ATTN_SCATTER_LAST_EN
    last_d  = last_q;
`endif
    if (in_fire) begin
      data_d  = bus_io.data_in;
      valid_d = head_sel_t'(1) << head_cnt;
`ifdef SELF_ATTN_SCATTER_LAST_EN
      last_d  = cnt_last;
`endif
    end else if (out_fire) begin
      valid_d = '0;
    end
  end

  // Output register shared by all heads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Lanes; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
`ifdef SELF_ATTN_SCATTER_LAST_EN
      last_q  <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef SELF_ATTN_SCATTER_LAST_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus_io.data_out       = data_q;
  assign bus_io.data_out_valid = valid_q;
  assign bus_io.data_in_ready  = in_ready;
`ifdef SELF_ATTN_SCATTER_LAST_EN
  assign bus_io.data_out_last  = last_q;
`endif

endmodule

// File: tb/tb_self_attention_head_data_scatter.sv
// Directed bench for the head scatter: 2 heads, 4x2 blocks per tensor,
// head0 owns column blocks 0-1 and head1 owns 2-3.
module tb_self_attention_head_data_scatter;

  localparam int unsigned NH    = 2;
  localparam int unsigned PREC  = 16;
  localparam int unsigned LANES = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  self_attention_head_data_scatter_if #(
    .NumHeads  (NH),
    .Precision (PREC),
    .Lanes     (LANES)
  ) bus ();

  self_attention_head_data_scatter #(
    .NUM_HEADS                 (NH),
    .IN_DATA_TENSOR_SIZE_DIM_0 (8),
    .IN_DATA_TENSOR_SIZE_DIM_1 (4),
    .IN_DATA_PARALLELISM_DIM_0 (2),
    .IN_DATA_PARALLELISM_DIM_1 (2),
    .IN_DATA_PRECISION_0       (PREC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  // Hand-derived routing per block position within a tensor (bit0 = head0).
  logic [1:0] exp_vld  [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
  logic       exp_last [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_block(input int tag);
    for (int i = 0; i < LANES; i++) begin
      bus.data_in[i] = PREC'(tag * 16 + i);
    end
  endtask

  task automatic check_data(input int tag);
    for (int i = 0; i < LANES; i++) begin
      check_eq($sformatf("data[%0d] tag %0d", i, tag), 32'(bus.data_out[i]),
               32'(PREC'(tag * 16 + i)));
    end
  endtask

  // Present one block, expect it accepted at the next edge and routed to exp_vld[pos].
  task automatic send_checked(input int tag, input int pos);
    drive_block(tag);
    bus.data_in_valid = 1'b1;
    #1;
    check_eq($sformatf("in_rdy tag %0d", tag), 32'(bus.data_in_ready), 32'd1);
    @(posedge clk);
    #1;
    check_eq($sformatf("vld tag %0d", tag), 32'(bus.data_out_valid), 32'(exp_vld[pos]));
    check_data(tag);
`ifdef SELF_ATTN_SCATTER_LAST_EN
    check_eq($sformatf("last tag %0d", tag), 32'(bus.data_out_last), 32'(exp_last[pos]));
`endif
  endtask

  task automatic drain_checked(input string tag);
    bus.data_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq(tag, 32'(bus.data_out_valid), 32'd0);
  endtask

  initial begin
    rst                = 1'b1;
    bus.data_in_valid  = 1'b0;
    bus.data_out_ready = 2'b00;
    drive_block(0);
    #12;
    check_eq("rst vld", 32'(bus.data_out_valid), 32'd0);
    check_eq("rst rdy", 32'(bus.data_in_ready), 32'd1);
    check_eq("rst data", 32'(bus.data_out[0]), 32'd0);
`ifdef SELF_ATTN_SCATTER_LAST_EN
    check_eq("rst last", 32'(bus.data_out_last), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full throughput, one tensor.
    bus.data_out_ready = 2'b11;
    for (int k = 0; k < 8; k++) send_checked(k, k);
    drain_checked("drain1");

    // Head0 stalled; head1's ready must not release block 0.
    bus.data_out_ready = 2'b10;
    send_checked(100, 0);
    drive_block(101);
    bus.data_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("stall rdy", 32'(bus.data_in_ready), 32'd0);
      check_eq("stall vld", 32'(bus.data_out_valid), 32'h1);
      check_eq("stall data", 32'(bus.data_out[0]), 32'd1600);
      @(posedge clk);
      #1;
    end
    bus.data_out_ready = 2'b11;
    for (int k = 1; k < 8; k++) send_checked(100 + k, k);
    drain_checked("drain2");

    // Two tensors back to back: block 8 wraps to head0 with no bubble.
    for (int k = 0; k < 16; k++) send_checked(200 + k, k % 8);
    drain_checked("drain3");

    // Async reset mid-tensor while head1 holds a block.
    for (int k = 0; k < 4; k++) send_checked(300 + k, k);
    bus.data_in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst vld", 32'(bus.data_out_valid), 32'd0);
    check_eq("arst data", 32'(bus.data_out[0]), 32'd0);
    check_eq("arst rdy", 32'(bus.data_in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_checked(310, 0);
    drain_checked("drain4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
